// File: rtl/fpu_apu_resp_adapter.sv
// APU-to-FPU request/response adapter with credit-bounded response FIFO.
// Optional macro FPU_RESP_BYPASS_EN: an FPU result reaches apu_r* in the same cycle when the FIFO is empty.
module fpu_apu_resp_adapter #(
  parameter int ID_WIDTH        = 9,
  parameter int NB_ARGS         = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int OP_BITS         = 4,
  parameter int FMT_BITS        = 3,
  parameter int IFMT_BITS       = 2,
  parameter int RND_BITS        = 3,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int RESP_DEPTH      = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush_i,
  input  logic                                       apu_req_i,
  output logic                                       apu_gnt_o,
  input  logic [ID_WIDTH-1:0]                        apu_ID_i,
  input  logic [NB_ARGS*DATA_WIDTH-1:0]              apu_operands_i,
  input  logic [OP_BITS+1:0]                         apu_op_i,
  input  logic [IFMT_BITS+2*FMT_BITS+RND_BITS-1:0]   apu_flags_i,
  input  logic                                       apu_rready_i,
  output logic                                       apu_rvalid_o,
  output logic [DATA_WIDTH-1:0]                      apu_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]                 apu_rflags_o,
  output logic [ID_WIDTH-1:0]                        apu_rID_o,
  output logic                                       fpu_valid_o,
  input  logic                                       fpu_ready_i,
  output logic [NB_ARGS*DATA_WIDTH-1:0]              fpu_operands_o,
  output logic [OP_BITS-1:0]                         fpu_op_o,
  output logic                                       fpu_op_mod_o,
  output logic                                       fpu_vec_op_o,
  output logic [FMT_BITS-1:0]                        fpu_src_fmt_o,
  output logic [FMT_BITS-1:0]                        fpu_dst_fmt_o,
  output logic [IFMT_BITS-1:0]                       fpu_int_fmt_o,
  output logic [RND_BITS-1:0]                        fpu_rnd_mode_o,
  output logic [ID_WIDTH-1:0]                        fpu_tag_o,
  input  logic                                       fpu_out_valid_i,
  input  logic [DATA_WIDTH-1:0]                      fpu_result_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]                 fpu_status_i,
  input  logic [ID_WIDTH-1:0]                        fpu_tag_i,
  output logic                                       fpu_out_ready_o,
  output logic                                       fpu_flush_o,
  output logic [$clog2(RESP_DEPTH+1)-1:0]            outstanding_o,
  output logic                                       busy_o,
  output logic                                       err_o
);
  localparam int CW = $clog2(RESP_DEPTH+1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW-1:0] MAXC  = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LASTP = PW'(RESP_DEPTH-1);

  // Handshakes: a request transfers when apu_req_i & apu_gnt_o; a response
  // transfers when apu_rvalid_o & apu_rready_i. No FPU result is ever stalled.
  logic [CW-1:0]              r_cnt, r_occ, w_cnt_nxt, w_occ_nxt;
  logic [PW-1:0]              r_wptr, r_rptr;
  logic                       r_err;
  logic [DATA_WIDTH-1:0]      r_res [RESP_DEPTH];
  logic [FLAGS_OUT_WIDTH-1:0] r_sts [RESP_DEPTH];
  logic [ID_WIDTH-1:0]        r_tag [RESP_DEPTH];
  logic w_room, w_issue, w_empty, w_unexp, w_res_ok, w_byp;
  logic w_rvalid, w_retire, w_pop, w_write;

  assign fpu_operands_o = apu_operands_i;
  assign fpu_op_o       = apu_op_i[OP_BITS-1:0];
  assign fpu_op_mod_o   = apu_op_i[OP_BITS];
  assign fpu_vec_op_o   = apu_op_i[OP_BITS+1];
  assign fpu_rnd_mode_o = apu_flags_i[RND_BITS-1:0];
  assign fpu_dst_fmt_o  = apu_flags_i[RND_BITS +: FMT_BITS];
  assign fpu_src_fmt_o  = apu_flags_i[RND_BITS+FMT_BITS +: FMT_BITS];
  assign fpu_int_fmt_o  = apu_flags_i[RND_BITS+2*FMT_BITS +: IFMT_BITS];
  assign fpu_tag_o      = apu_ID_i;

  assign w_room      = (r_cnt < MAXC);
  assign apu_gnt_o   = fpu_ready_i & w_room & ~flush_i & ~rst;
  assign fpu_valid_o = apu_req_i & w_room & ~flush_i & ~rst;
  assign w_issue     = apu_req_i & apu_gnt_o;
  assign fpu_flush_o = flush_i & ~rst;
  assign fpu_out_ready_o = 1'b1;

  // A result with nothing pending inside the FPU (occupancy == credits) is spurious.
  assign w_empty  = (r_occ == '0);
  assign w_unexp  = fpu_out_valid_i & (r_occ == r_cnt) & ~flush_i;
  assign w_res_ok = fpu_out_valid_i & ~w_unexp & ~flush_i;
`ifdef FPU_RESP_BYPASS_EN
  assign w_byp = w_empty & w_res_ok;
`else
  assign w_byp = 1'b0;
`endif
  assign w_rvalid = (~w_empty | w_byp) & ~rst;
  assign w_retire = w_rvalid & apu_rready_i;
  assign w_pop    = ~w_empty & apu_rready_i;
  assign w_write  = w_res_ok & ~(w_byp & apu_rready_i);

  assign apu_rvalid_o = w_rvalid;
  assign apu_rdata_o  = ~w_rvalid ? '0 : (w_byp ? fpu_result_i : r_res[r_rptr]);
  assign apu_rflags_o = ~w_rvalid ? '0 : (w_byp ? fpu_status_i : r_sts[r_rptr]);
  assign apu_rID_o    = ~w_rvalid ? '0 : (w_byp ? fpu_tag_i    : r_tag[r_rptr]);
  assign outstanding_o = r_cnt;
  assign busy_o        = (r_cnt != '0);
  assign err_o         = r_err;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_occ_nxt = r_occ;
    if (w_issue && !w_retire) w_cnt_nxt = r_cnt + CW'(1);
    else if (w_retire && !w_issue) w_cnt_nxt = r_cnt - CW'(1);
    if (w_write && !w_pop) w_occ_nxt = r_occ + CW'(1);
    else if (w_pop && !w_write) w_occ_nxt = r_occ - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_occ  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_unexp) r_err <= 1'b1;
      if (flush_i) begin
        r_cnt  <= '0;
        r_occ  <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_occ <= w_occ_nxt;
        if (w_write) r_wptr <= (r_wptr == LASTP) ? '0 : r_wptr + PW'(1);
        if (w_pop)   r_rptr <= (r_rptr == LASTP) ? '0 : r_rptr + PW'(1);
      end
    end
  end

  // Storage is deliberately left unreset; only pointers and counts matter.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_res[r_wptr] <= fpu_result_i;
      r_sts[r_wptr] <= fpu_status_i;
      r_tag[r_wptr] <= fpu_tag_i;
    end
  end
endmodule

// File: tb/tb_fpu_apu_resp_adapter.sv
// Bench for fpu_apu_resp_adapter: directed steps plus random traffic against a queue-based model.
module tb_fpu_apu_resp_adapter;
  localparam int IDW = 9, NA = 3, DW = 32, OPB = 4, FMB = 3, IFB = 2, RB = 3, FOW = 5, DEPTH = 4;
  localparam int OPW = OPB + 2, FIW = IFB + 2*FMB + RB, CW = $clog2(DEPTH+1);
  localparam int EW = DW + FOW + IDW;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic flush_i, apu_req_i, apu_gnt_o, apu_rready_i, apu_rvalid_o;
  logic [IDW-1:0] apu_ID_i, apu_rID_o, fpu_tag_o, fpu_tag_i;
  logic [NA*DW-1:0] apu_operands_i, fpu_operands_o;
  logic [OPW-1:0] apu_op_i;
  logic [FIW-1:0] apu_flags_i;
  logic [DW-1:0] apu_rdata_o, fpu_result_i;
  logic [FOW-1:0] apu_rflags_o, fpu_status_i;
  logic fpu_valid_o, fpu_ready_i, fpu_op_mod_o, fpu_vec_op_o;
  logic [OPB-1:0] fpu_op_o;
  logic [FMB-1:0] fpu_src_fmt_o, fpu_dst_fmt_o;
  logic [IFB-1:0] fpu_int_fmt_o;
  logic [RB-1:0] fpu_rnd_mode_o;
  logic fpu_out_valid_i, fpu_out_ready_o, fpu_flush_o, busy_o, err_o;
  logic [CW-1:0] outstanding_o;

  fpu_apu_resp_adapter #(
    .ID_WIDTH(IDW), .NB_ARGS(NA), .DATA_WIDTH(DW), .OP_BITS(OPB), .FMT_BITS(FMB),
    .IFMT_BITS(IFB), .RND_BITS(RB), .FLAGS_OUT_WIDTH(FOW), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
    .apu_ID_i(apu_ID_i), .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i),
    .apu_flags_i(apu_flags_i), .apu_rready_i(apu_rready_i), .apu_rvalid_o(apu_rvalid_o),
    .apu_rdata_o(apu_rdata_o), .apu_rflags_o(apu_rflags_o), .apu_rID_o(apu_rID_o),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_operands_o(fpu_operands_o),
    .fpu_op_o(fpu_op_o), .fpu_op_mod_o(fpu_op_mod_o), .fpu_vec_op_o(fpu_vec_op_o),
    .fpu_src_fmt_o(fpu_src_fmt_o), .fpu_dst_fmt_o(fpu_dst_fmt_o), .fpu_int_fmt_o(fpu_int_fmt_o),
    .fpu_rnd_mode_o(fpu_rnd_mode_o), .fpu_tag_o(fpu_tag_o), .fpu_out_valid_i(fpu_out_valid_i),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .fpu_out_ready_o(fpu_out_ready_o), .fpu_flush_o(fpu_flush_o), .outstanding_o(outstanding_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  int vectors = 0, miscompares = 0;
  // Reference: credits as an integer, responses as a queue, FPU pipeline as a tag queue.
  logic [EW-1:0]  exp_q[$];
  logic [IDW-1:0] pend[$];
  logic [IDW-1:0] rx[$];
  int m_cnt = 0;
  bit m_err = 0, m_issue = 0;
  logic [IDW-1:0] nxt_id = '0;
  logic [DW-1:0]  nxt_res = '0;
  logic [OPW-1:0] nxt_op = '0;
  logic [FIW-1:0] nxt_flags = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields();
    nxt_id = IDW'($urandom); nxt_res = $urandom; nxt_op = OPW'($urandom); nxt_flags = FIW'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, apu_gnt_o, 0);      chk({tag, "_fvalid"}, fpu_valid_o, 0);
    chk({tag, "_rvalid"}, apu_rvalid_o, 0); chk({tag, "_rdata"}, apu_rdata_o, 0);
    chk({tag, "_rflags"}, apu_rflags_o, 0); chk({tag, "_rid"}, apu_rID_o, 0);
    chk({tag, "_outst"}, outstanding_o, 0); chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err"}, err_o, 0);           chk({tag, "_flush"}, fpu_flush_o, 0);
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  task automatic cyc(input bit req, input bit rdy, input bit rrdy, input bit fov, input bit fl);
    logic [EW-1:0] head;
    logic [FOW-1:0] sts;
    bit room, e_gnt, e_rv, retire, unexp;
    sts = FOW'($urandom);
    apu_req_i = req; apu_ID_i = nxt_id; apu_operands_i = {$urandom, $urandom, $urandom};
    apu_op_i = nxt_op; apu_flags_i = nxt_flags; fpu_ready_i = rdy; apu_rready_i = rrdy;
    flush_i = fl; fpu_out_valid_i = fov; fpu_result_i = nxt_res; fpu_status_i = sts;
    fpu_tag_i = (pend.size() > 0) ? pend[0] : IDW'($urandom);
    #1;
    room  = (m_cnt < DEPTH);
    e_gnt = rdy && room && !fl;
    e_rv  = (exp_q.size() > 0);
    head  = e_rv ? exp_q[0] : '0;
    chk("gnt", apu_gnt_o, e_gnt);
    chk("fpu_valid", fpu_valid_o, req && room && !fl);
    chk("rvalid", apu_rvalid_o, e_rv);
    chk("rdata", apu_rdata_o, head[FOW+IDW +: DW]);
    chk("rflags", apu_rflags_o, head[IDW +: FOW]);
    chk("rid", apu_rID_o, head[IDW-1:0]);
    chk("outstanding", outstanding_o, m_cnt);
    chk("busy", busy_o, m_cnt != 0);
    chk("err", err_o, m_err);
    chk("fpu_flush", fpu_flush_o, fl);
    chk("out_ready", fpu_out_ready_o, 1);
    chk("fpu_tag", fpu_tag_o, nxt_id);
    chk("operands", fpu_operands_o, apu_operands_i);
    chk("op_fields", {fpu_vec_op_o, fpu_op_mod_o, fpu_op_o}, nxt_op);
    chk("flag_fields", {fpu_int_fmt_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_rnd_mode_o}, nxt_flags);
    m_issue = req && e_gnt;
    retire  = e_rv && rrdy;
    unexp   = fov && (exp_q.size() == m_cnt);
    if (fl) begin
      m_cnt = 0; exp_q.delete(); pend.delete();
    end else begin
      if (unexp) m_err = 1;
      if (retire) begin
        rx.push_back(exp_q[0][IDW-1:0]);
        void'(exp_q.pop_front());
      end
      if (fov && !unexp) begin
        exp_q.push_back({nxt_res, sts, fpu_tag_i});
        if (pend.size() > 0) void'(pend.pop_front());
      end
      if (m_issue) pend.push_back(nxt_id);
      m_cnt = m_cnt + int'(m_issue) - int'(retire);
    end
    @(negedge clk);
  endtask

  initial begin
    int issued;
    flush_i = 0; apu_req_i = 0; apu_ID_i = '0; apu_operands_i = '0; apu_op_i = '0;
    apu_flags_i = '0; apu_rready_i = 0; fpu_ready_i = 0; fpu_out_valid_i = 0;
    fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
    // Reset with every input trying to provoke an output
    #1 apu_req_i = 1; fpu_ready_i = 1; apu_rready_i = 1; flush_i = 1; fpu_out_valid_i = 1;
    #1 chk_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Single op with field unpacking
    nxt_id = 9'h05; nxt_op = 6'b10_0011; nxt_flags = 11'b01_000_001_010;
    apu_op_i = nxt_op; apu_flags_i = nxt_flags;
    #1;
    chk("vec_op", fpu_vec_op_o, 1);   chk("op_mod", fpu_op_mod_o, 0); chk("op", fpu_op_o, 3);
    chk("int_fmt", fpu_int_fmt_o, 1); chk("src_fmt", fpu_src_fmt_o, 0);
    chk("dst_fmt", fpu_dst_fmt_o, 1); chk("rnd_mode", fpu_rnd_mode_o, 2);
    cyc(1, 1, 0, 0, 0);
    nxt_res = 32'h3F80_0000;
    cyc(0, 1, 0, 1, 0);
    #1 chk("single_rvalid", apu_rvalid_o, 1); chk("single_rid", apu_rID_o, 9'h05);
    chk("single_rdata", apu_rdata_o, 32'h3F80_0000);
    cyc(0, 1, 1, 0, 0);

    // Credit limit
    for (int i = 0; i < 5; i++) begin rand_fields(); cyc(1, 1, 0, 0, 0); end
    #1 chk("credit_outst", outstanding_o, 4); chk("credit_gnt", apu_gnt_o, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 0);
    #1 chk("credit_reopen", apu_gnt_o, 1);
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 50 && m_cnt > 0; i++) cyc(0, 1, 1, pend.size() > 0, 0);
    chk("drain_a", outstanding_o, 0);

    // Ordering and wrap-around with toggling rready
    rx.delete(); issued = 0; nxt_id = '0;
    for (int k = 0; k < 200 && (issued < 10 || m_cnt > 0); k++) begin
      nxt_res = $urandom; nxt_op = OPW'($urandom); nxt_flags = FIW'($urandom);
      nxt_id = IDW'(issued);
      cyc(issued < 10, 1, k[0], (pend.size() > 0) && ($urandom_range(0, 1) == 1), 0);
      if (m_issue) issued++;
    end
    chk("order_count", rx.size(), 10);
    for (int i = 0; i < 10; i++) chk("order_tag", (i < rx.size()) ? rx[i] : 'x, i);

    // Simultaneous issue and retire at two credits, then flush with three outstanding
    rand_fields(); cyc(1, 1, 0, 0, 0); rand_fields(); cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0); cyc(0, 1, 0, 1, 0);
    rand_fields(); cyc(1, 1, 1, 0, 0);
    #1 chk("cnt_hold", outstanding_o, 2);
    rand_fields(); cyc(1, 1, 0, 0, 0);
    #1 chk("pre_flush", outstanding_o, 3);
    cyc(0, 1, 0, 1, 1);
    flush_i = 0;
    #1 chk("flush_outst", outstanding_o, 0); chk("flush_rvalid", apu_rvalid_o, 0);
    chk("flush_err", err_o, 0); chk("flush_pulse", fpu_flush_o, 0);

    // Random traffic
    repeat (300) begin
      rand_fields();
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          (pend.size() > 0) && ($urandom_range(0, 2) != 0), $urandom_range(0, 39) == 0);
    end

    // Spurious result
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 1, 0, 0);
    #1 chk("err_sticky", err_o, 1); chk("spurious_drop", apu_rvalid_o, 0);

    // Asynchronous reset mid-stream
    rand_fields(); cyc(1, 1, 0, 0, 0); rand_fields(); cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    apu_req_i = 1; fpu_ready_i = 1; apu_rready_i = 0; flush_i = 0;
    #2 rst = 1;
    #1 chk_zero("midrst");
    m_cnt = 0; m_err = 0; exp_q.delete(); pend.delete();
    @(negedge clk);
    rst = 0;
    repeat (20) begin
      rand_fields();
      cyc(1, 1, $urandom_range(0, 1) == 1, (pend.size() > 0) && ($urandom_range(0, 1) == 1), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
